// File: rtl/memory_stage_pkg.sv
// Shared constants for the RV32I memory stage: funct3 access codes, result-source
// encodings, bus FSM states and access-size decoding.
package memory_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
    localparam logic [1:0] RESULTSRC_PC4  = 2'b10;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } access_size_t;

    // Reserved funct3 codes fall through to a full-word access.
    function automatic access_size_t decode_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SIZE_BYTE;
            F3_H, F3_HU: return SIZE_HALF;
            F3_W:        return SIZE_WORD;
            default:     return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_signed_load(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus; the memory stage is the master, data memory the slave.
interface memory_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    dmem_req;
    logic                    dmem_we;
    logic [ADDR_WIDTH-1:0]   dmem_addr;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic [DATA_WIDTH/8-1:0] dmem_be;
    logic                    dmem_ack;
    logic [DATA_WIDTH-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/memory_stage_load_store_align.sv
// Combinational byte-lane logic: store byte enables and lane replication, load lane
// extraction with sign/zero extension, and misaligned-access detection.
module memory_stage_load_store_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    access_size_t size;
    logic         sign_ext;
    logic [7:0]   lane_byte;
    logic [15:0]  lane_half;

    assign size     = decode_size(funct3);
    assign sign_ext = is_signed_load(funct3);

    always_comb begin
        byte_en    = 4'b1111;
        store_word = store_data;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: misaligned = (addr_lo != 2'b00);
        endcase
    end

    always_comb begin
        lane_byte = load_word[7:0];
        case (addr_lo)
            2'd0: lane_byte = load_word[7:0];
            2'd1: lane_byte = load_word[15:8];
            2'd2: lane_byte = load_word[23:16];
            2'd3: lane_byte = load_word[31:24];
        endcase
        lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
        load_data = load_word;
        case (size)
            SIZE_BYTE: load_data = {{24{sign_ext & lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_data = {{16{sign_ext & lane_half[15]}}, lane_half};
            default:   load_data = load_word;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the RV32I pipeline: data-memory access over a req/ack bus with wait states,
// lane alignment, misalign/timeout detection, stall generation and the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid_m,
    input  logic [DATA_WIDTH-1:0] i_alu_result_m,
    input  logic [DATA_WIDTH-1:0] i_write_data_m,
    input  logic [2:0]            i_funct3_m,
    input  logic                  i_regwrite_m,
    input  logic                  i_memwrite_m,
    input  logic [1:0]            i_resultsrc_m,
    input  logic [4:0]            i_rd_addr_m,
    input  logic [DATA_WIDTH-1:0] i_pc4_m,
    output logic [DATA_WIDTH-1:0] o_forward_m,
    output logic                  o_stall_m,
    memory_stage_if.master        dmem,
    output logic                  o_regwrite_w,
    output logic [1:0]            o_resultsrc_w,
    output logic [4:0]            o_rd_addr_w,
    output logic [DATA_WIDTH-1:0] o_alu_result_w,
    output logic [DATA_WIDTH-1:0] o_read_data_w,
    output logic [DATA_WIDTH-1:0] o_pc4_w,
    output logic                  o_misaligned_w,
    output logic                  o_bus_err_w
);

    localparam int CW = $clog2(TIMEOUT);

    mem_state_t     state;
    logic [CW-1:0]  wait_cnt;
    logic           mem_op;
    logic           misaligned;
    logic           req;
    logic           timeout_hit;
    logic           stall;
    logic [3:0]     lane_be;
    logic [31:0]    lane_wdata;
    logic [31:0]    load_data;

    memory_stage_load_store_align u_align (
        .funct3     (i_funct3_m),
        .addr_lo    (i_alu_result_m[1:0]),
        .store_data (i_write_data_m),
        .load_word  (dmem.dmem_rdata),
        .byte_en    (lane_be),
        .store_word (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign mem_op = i_valid_m & (i_memwrite_m | (i_resultsrc_m == RESULTSRC_LOAD));

    // Reset gates the request directly so the bus sees it drop without waiting for a clock.
    assign req         = mem_op & ~misaligned & ~i_rst;
    assign timeout_hit = req & ~dmem.dmem_ack & (state == WAIT) & (wait_cnt == CW'(TIMEOUT - 1));
    assign stall       = req & ~dmem.dmem_ack & ~timeout_hit;

    assign o_stall_m       = stall;
    assign o_forward_m     = i_alu_result_m;
    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & i_memwrite_m;
    assign dmem.dmem_addr  = {i_alu_result_m[ADDR_WIDTH-1:2], 2'b00};
    assign dmem.dmem_wdata = lane_wdata;
    assign dmem.dmem_be    = lane_be;

    // The EX/MEM register is frozen by the stall, so the bus outputs stay stable while waiting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !dmem.dmem_ack) begin
                        state    <= WAIT;
                        wait_cnt <= CW'(1);
                    end
                end
                WAIT: begin
                    if (!req || dmem.dmem_ack || timeout_hit) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // A stalled cycle pushes a bubble into WB; the real capture happens on the ack edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || stall) begin
            o_regwrite_w   <= 1'b0;
            o_resultsrc_w  <= '0;
            o_rd_addr_w    <= '0;
            o_alu_result_w <= '0;
            o_read_data_w  <= '0;
            o_pc4_w        <= '0;
            o_misaligned_w <= 1'b0;
            o_bus_err_w    <= 1'b0;
        end else begin
            o_regwrite_w   <= i_valid_m & i_regwrite_m & ~(mem_op & misaligned) & ~timeout_hit;
            o_resultsrc_w  <= i_resultsrc_m;
            o_rd_addr_w    <= i_rd_addr_m;
            o_alu_result_w <= i_alu_result_m;
            o_read_data_w  <= load_data;
            o_pc4_w        <= i_pc4_m;
            o_misaligned_w <= mem_op & misaligned;
            o_bus_err_w    <= timeout_hit;
        end
    end

endmodule
